hist_frame_sequencer: RTL

//   Per-frame controller for the gray-level histogram RAM feeding the threshold path.
//   - During a frame: read-modify-write bin increments from the RGB-to-gray stream.
//   - After the frame: sweeps all bins, builds the cumulative histogram, finds the 25/50/75% thresholds, clears the bins.
//   - Publishes thresholds and the max bin count once per frame to the thresholders and the histogram displayers.

---
 rtl/hist_frame_sequencer_if.sv | 40 ++++
 rtl/hist_frame_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hist_frame_sequencer_if.sv
// Signal bundle between the histogram frame sequencer, the pixel stream,
// the histogram/cumulative RAMs and the result consumers.
interface hist_frame_sequencer_if #(
    parameter int CNT_W = 20
);
    logic             iFval;
    logic [7:0]       iGray;
    logic             iGrayValid;
    logic [7:0]       oHistRdAddr;
    logic [CNT_W-1:0] iHistRdData;
    logic [7:0]       oHistWrAddr;
    logic [CNT_W-1:0] oHistWrData;
    logic             oHistWrEn;
    logic [7:0]       oCumWrAddr;
    logic [CNT_W-1:0] oCumWrData;
    logic             oCumWrEn;
    logic [7:0]       oThresh25;
    logic [7:0]       oThresh50;
    logic [7:0]       oThresh75;
    logic [CNT_W-1:0] oMaxValue;
    logic             oDone;
    logic             oBusy;
    logic             oFrameDrop;

    modport master (
        input  iFval, iGray, iGrayValid, iHistRdData,
        output oHistRdAddr, oHistWrAddr, oHistWrData, oHistWrEn,
               oCumWrAddr, oCumWrData, oCumWrEn,
               oThresh25, oThresh50, oThresh75, oMaxValue,
               oDone, oBusy, oFrameDrop
    );

    modport slave (
        output iFval, iGray, iGrayValid, iHistRdData,
        input  oHistRdAddr, oHistWrAddr, oHistWrData, oHistWrEn,
               oCumWrAddr, oCumWrData, oCumWrEn,
               oThresh25, oThresh50, oThresh75, oMaxValue,
               oDone, oBusy, oFrameDrop
    );
endinterface

// File: rtl/hist_frame_sequencer.sv
// Per-frame histogram controller: accumulates gray bins during a frame, then
// sweeps them into a cumulative histogram, finds 25/50/75% thresholds and clears.
module hist_frame_sequencer #(
    parameter int CNT_W = 20
) (
    input  logic                  iClk,
    input  logic                  iRst,
    hist_frame_sequencer_if.master bus
);
    localparam int               NBINS = 256;
    localparam logic [CNT_W-1:0] CMAX  = '1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ACCUM, S_DRAIN, S_SWEEP, S_PUBLISH
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_fval_prev;
    logic [7:0]       r_init_addr;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_s1_vld;
    logic [7:0]       r_s1_addr;
    logic             r_lw_vld;
    logic [7:0]       r_lw_addr;
    logic [CNT_W-1:0] r_lw_data;
    logic [8:0]       r_k;
    logic             r_sw_vld;
    logic [7:0]       r_sw_addr;
    logic [CNT_W-1:0] r_cum, r_max;
    logic [CNT_W-1:0] r_t25, r_t50, r_t75;
    logic             r_f25, r_f50, r_f75;
    logic [7:0]       r_k25, r_k50, r_k75;
    logic [7:0]       r_th25, r_th50, r_th75;
    logic [CNT_W-1:0] r_max_pub;
    logic             r_done, r_drop;

    logic             w_rise, w_fall, w_px;
    logic [CNT_W-1:0] w_s1_base, w_s1_inc;
    logic [CNT_W:0]   w_cum_sum;
    logic [CNT_W-1:0] w_cum_next;
    logic [CNT_W+1:0] w_p3;

    assign w_rise = bus.iFval & ~r_fval_prev;
    assign w_fall = ~bus.iFval & r_fval_prev;
    assign w_px   = (r_state == S_ACCUM) & bus.iGrayValid;

    // The RAM returns pre-write data on a same-address read/write, so the
    // previous cycle's increment is forwarded over the stale read.
    assign w_s1_base  = (r_lw_vld && r_lw_addr == r_s1_addr) ? r_lw_data : bus.iHistRdData;
    assign w_s1_inc   = (w_s1_base == CMAX) ? CMAX : w_s1_base + 1'b1;
    assign w_cum_sum  = {1'b0, r_cum} + {1'b0, bus.iHistRdData};
    assign w_cum_next = w_cum_sum[CNT_W] ? CMAX : w_cum_sum[CNT_W-1:0];
    assign w_p3       = {2'b00, r_pcnt} + {1'b0, r_pcnt, 1'b0};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:    if (r_init_addr == 8'(NBINS - 1)) w_state_nxt = S_IDLE;
            S_IDLE:    if (w_rise) w_state_nxt = S_ACCUM;
            S_ACCUM:   if (w_fall) w_state_nxt = S_DRAIN;
            S_DRAIN:   w_state_nxt = S_SWEEP;
            S_SWEEP:   if (r_sw_vld && r_sw_addr == 8'(NBINS - 1)) w_state_nxt = S_PUBLISH;
            S_PUBLISH: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        bus.oHistRdAddr = '0;
        bus.oHistWrAddr = '0;
        bus.oHistWrData = '0;
        bus.oHistWrEn   = 1'b0;
        bus.oCumWrAddr  = '0;
        bus.oCumWrData  = '0;
        bus.oCumWrEn    = 1'b0;
        case (r_state)
            S_INIT: begin
                bus.oHistWrAddr = r_init_addr;
                bus.oHistWrEn   = 1'b1;
            end
            S_ACCUM, S_DRAIN: begin
                if (w_px) bus.oHistRdAddr = bus.iGray;
                if (r_s1_vld) begin
                    bus.oHistWrAddr = r_s1_addr;
                    bus.oHistWrData = w_s1_inc;
                    bus.oHistWrEn   = 1'b1;
                end
            end
            S_SWEEP: begin
                if (!r_k[8]) bus.oHistRdAddr = r_k[7:0];
                if (r_sw_vld) begin
                    bus.oHistWrAddr = r_sw_addr;
                    bus.oHistWrEn   = 1'b1;
                    bus.oCumWrAddr  = r_sw_addr;
                    bus.oCumWrData  = w_cum_next;
                    bus.oCumWrEn    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= S_INIT;
            r_fval_prev <= 1'b0;
            r_init_addr <= '0;
            r_pcnt      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= '0;
            r_lw_vld    <= 1'b0;
            r_lw_addr   <= '0;
            r_lw_data   <= '0;
            r_k         <= '0;
            r_sw_vld    <= 1'b0;
            r_sw_addr   <= '0;
            r_cum       <= '0;
            r_max       <= '0;
            r_t25       <= '0;
            r_t50       <= '0;
            r_t75       <= '0;
            r_f25       <= 1'b0;
            r_f50       <= 1'b0;
            r_f75       <= 1'b0;
            r_k25       <= '0;
            r_k50       <= '0;
            r_k75       <= '0;
            r_th25      <= '0;
            r_th50      <= '0;
            r_th75      <= '0;
            r_max_pub   <= '0;
            r_done      <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fval_prev <= bus.iFval;
            r_init_addr <= (r_state == S_INIT) ? r_init_addr + 8'd1 : 8'd0;

            r_s1_vld  <= w_px;
            r_s1_addr <= bus.iGray;
            r_lw_vld  <= r_s1_vld;
            r_lw_addr <= r_s1_addr;
            r_lw_data <= w_s1_inc;

            if (r_state == S_IDLE && w_rise) begin
                r_pcnt <= '0;
                r_max  <= '0;
            end else if (w_px && r_pcnt != CMAX) begin
                r_pcnt <= r_pcnt + 1'b1;
            end

            // Pixel count is final here: the last pixel lands in the falling-edge cycle.
            if (r_state == S_DRAIN) begin
                r_t25 <= r_pcnt >> 2;
                r_t50 <= r_pcnt >> 1;
                r_t75 <= w_p3[CNT_W+1:2];
                r_cum <= '0;
                r_k   <= '0;
                r_f25 <= 1'b0;
                r_f50 <= 1'b0;
                r_f75 <= 1'b0;
                r_k25 <= '0;
                r_k50 <= '0;
                r_k75 <= '0;
            end

            if (r_state == S_SWEEP) begin
                r_k       <= r_k + {8'd0, ~r_k[8]};
                r_sw_vld  <= ~r_k[8];
                r_sw_addr <= r_k[7:0];
                if (r_sw_vld) begin
                    r_cum <= w_cum_next;
                    if (bus.iHistRdData > r_max) r_max <= bus.iHistRdData;
                    if (!r_f25 && w_cum_next >= r_t25) begin r_f25 <= 1'b1; r_k25 <= r_sw_addr; end
                    if (!r_f50 && w_cum_next >= r_t50) begin r_f50 <= 1'b1; r_k50 <= r_sw_addr; end
                    if (!r_f75 && w_cum_next >= r_t75) begin r_f75 <= 1'b1; r_k75 <= r_sw_addr; end
                end
            end else begin
                r_sw_vld <= 1'b0;
            end

            r_done <= (r_state == S_PUBLISH);
            if (r_state == S_PUBLISH) begin
                r_th25    <= r_k25;
                r_th50    <= r_k50;
                r_th75    <= r_k75;
                r_max_pub <= r_max;
            end

            r_drop <= w_rise && (r_state != S_IDLE) && (r_state != S_ACCUM);
        end
    end

    assign bus.oThresh25  = r_th25;
    assign bus.oThresh50  = r_th50;
    assign bus.oThresh75  = r_th75;
    assign bus.oMaxValue  = r_max_pub;
    assign bus.oDone      = r_done;
    assign bus.oBusy      = (r_state != S_IDLE);
    assign bus.oFrameDrop = r_drop;
endmodule
